config_bank_tmr_scrub: RTL and testbench

- Parametrised successor to the single 8-bit TMR configuration cell.
- Holds DEPTH configuration words of WIDTH bits, each stored as three internal copies (A/B/C).
- Reads go through a bitwise majority vote.
- A background scrubber walks all addresses, rewrites any word whose copies disagree, and counts corrections.
- Sits between the slow-control register interface and the configured logic. Error injection is provided for verification.

---
 rtl/config_bank_tmr_pkg.sv | 14 +
 rtl/tmr_word_voter.sv | 16 +
 rtl/config_bank_tmr_scrub.sv | 144 ++++++++++++++
 tb/tb_config_bank_tmr_scrub.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/config_bank_tmr_pkg.sv
// Shared types for the TMR configuration bank: scrubber states and copy indices.
package config_bank_tmr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    CHECK = 2'd2
  } scrubState_e;

  localparam logic [1:0] COPY_A = 2'd0;
  localparam logic [1:0] COPY_B = 2'd1;
  localparam logic [1:0] COPY_C = 2'd2;

endpackage

// File: rtl/tmr_word_voter.sv
// Bitwise 2-of-3 majority vote over three copies of a word, plus a disagreement flag.
module tmr_word_voter #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] voted,
  output logic             mismatch
);

  // Each bit resolves independently; two corrupted copies of a bit win the vote.
  assign voted    = (a & b) | (a & c) | (b & c);
  assign mismatch = |((a ^ b) | (a ^ c));

endmodule

// File: rtl/config_bank_tmr_scrub.sv
// Triplicated configuration word bank with voted reads and a background scrubber
// that rewrites disagreeing words and counts the corrections it commits.
module config_bank_tmr_scrub
  import config_bank_tmr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 8,
  parameter int SCRUB_GAP = 4,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_mismatch,
  input  logic             scrub_en,
  output logic             scrub_busy,
  output logic [AW-1:0]    scrub_ptr,
  output logic             fix_pulse,
  output logic [CNT_W-1:0] fix_count,
  input  logic             cnt_clr,
  input  logic             inj_en,
  input  logic [1:0]       inj_copy,
  input  logic [AW-1:0]    inj_addr,
  input  logic [WIDTH-1:0] inj_mask
);

  localparam int               GAP_W     = $clog2(SCRUB_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(SCRUB_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [AW-1:0]    LAST_ADDR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] copyA [DEPTH];
  logic [WIDTH-1:0] copyB [DEPTH];
  logic [WIDTH-1:0] copyC [DEPTH];

  scrubState_e      state;
  logic [GAP_W-1:0] gapCnt;
  logic [AW-1:0]    scrubPtr;
  logic [WIDTH-1:0] scrubVoted;
  logic             scrubMismatch;
  logic             doFix;

  tmr_word_voter #(.WIDTH(WIDTH)) readVoter (
    .a        (copyA[rd_addr]),
    .b        (copyB[rd_addr]),
    .c        (copyC[rd_addr]),
    .voted    (rd_data),
    .mismatch (rd_mismatch)
  );

  tmr_word_voter #(.WIDTH(WIDTH)) scrubVoter (
    .a        (copyA[scrubPtr]),
    .b        (copyB[scrubPtr]),
    .c        (copyC[scrubPtr]),
    .voted    (scrubVoted),
    .mismatch (scrubMismatch)
  );

  // A correction yields to a same-cycle write at the address being checked.
  assign doFix      = (state == CHECK) && scrubMismatch && !(wr_en && (wr_addr == scrubPtr));
  assign scrub_busy = (state != IDLE);
  assign scrub_ptr  = scrubPtr;

  // Storage update per address with priority write > scrub correction > injection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        copyA[i] <= '0;
        copyB[i] <= '0;
        copyC[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_en && (wr_addr == AW'(i))) begin
          copyA[i] <= wr_data;
          copyB[i] <= wr_data;
          copyC[i] <= wr_data;
        end else if (doFix && (scrubPtr == AW'(i))) begin
          copyA[i] <= scrubVoted;
          copyB[i] <= scrubVoted;
          copyC[i] <= scrubVoted;
        end else if (inj_en && (inj_addr == AW'(i))) begin
          case (inj_copy)
            COPY_A:  copyA[i] <= copyA[i] ^ inj_mask;
            COPY_B:  copyB[i] <= copyB[i] ^ inj_mask;
            COPY_C:  copyC[i] <= copyC[i] ^ inj_mask;
            default: ;
          endcase
        end
      end
    end
  end

  // Scrubber sequencing, address walk and the saturating correction counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      gapCnt    <= '0;
      scrubPtr  <= '0;
      fix_pulse <= 1'b0;
      fix_count <= '0;
    end else begin
      fix_pulse <= doFix;
      if (cnt_clr) begin
        fix_count <= '0;
      end else if (doFix && (fix_count != CNT_MAX)) begin
        fix_count <= fix_count + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (scrub_en) begin
            state  <= GAP;
            gapCnt <= GAP_LOAD;
          end
        end
        GAP: begin
          if (!scrub_en) begin
            state <= IDLE;
          end else if (gapCnt == '0) begin
            state <= CHECK;
          end else begin
            gapCnt <= gapCnt - GAP_W'(1);
          end
        end
        CHECK: begin
          scrubPtr <= (scrubPtr == LAST_ADDR) ? '0 : scrubPtr + AW'(1);
          if (scrub_en) begin
            state  <= GAP;
            gapCnt <= GAP_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_bank_tmr_scrub.sv
// Directed bench for the TMR configuration bank: voting, injection, scrub cadence,
// write/correction collision, counter saturation and clear, pause/wrap and async reset.
module tb_config_bank_tmr_scrub;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int AW        = 4;
  localparam int CNT_W     = 8;
  localparam int SCRUB_GAP = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_mismatch;
  logic             scrub_en;
  logic             scrub_busy;
  logic [AW-1:0]    scrub_ptr;
  logic             fix_pulse;
  logic [CNT_W-1:0] fix_count;
  logic             cnt_clr;
  logic             inj_en;
  logic [1:0]       inj_copy;
  logic [AW-1:0]    inj_addr;
  logic [WIDTH-1:0] inj_mask;

  int vectors     = 0;
  int miscompares = 0;

  config_bank_tmr_scrub #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W),
    .SCRUB_GAP (SCRUB_GAP)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_mismatch (rd_mismatch),
    .scrub_en    (scrub_en),
    .scrub_busy  (scrub_busy),
    .scrub_ptr   (scrub_ptr),
    .fix_pulse   (fix_pulse),
    .fix_count   (fix_count),
    .cnt_clr     (cnt_clr),
    .inj_en      (inj_en),
    .inj_copy    (inj_copy),
    .inj_addr    (inj_addr),
    .inj_mask    (inj_mask)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic readCheck(input string tag, input logic [AW-1:0] addr,
                           input logic [WIDTH-1:0] expData, input logic expMis);
    rd_addr = addr;
    #1;
    checkOutput({tag, "/rd_data"}, 32'(rd_data), 32'(expData));
    checkOutput({tag, "/rd_mismatch"}, 32'(rd_mismatch), 32'(expMis));
  endtask

  task automatic applyStimulus(input logic [1:0] copy, input logic [AW-1:0] addr, input logic [WIDTH-1:0] mask);
    inj_en   = 1'b1;
    inj_copy = copy;
    inj_addr = addr;
    inj_mask = mask;
    tick();
    inj_en   = 1'b0;
  endtask

  task automatic waitFix(input int limit, output int cyc);
    cyc = -1;
    for (int n = 1; n <= limit; n++) begin
      tick();
      if (fix_pulse === 1'b1) begin
        cyc = n;
        break;
      end
    end
  endtask

  task automatic scrubRound(output int pulses);
    for (int a = 0; a < DEPTH; a++) applyStimulus(2'd2, AW'(a), 8'h80);
    scrub_en = 1'b1;
    pulses   = 0;
    repeat (81) begin
      tick();
      if (fix_pulse === 1'b1) pulses++;
    end
    scrub_en = 1'b0;
    tick();
  endtask

  initial begin
    int cyc;
    int pulses;
    int expCnt;
    logic [AW-1:0] others [5];
    others = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd15};

    rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    scrub_en = 1'b0; cnt_clr = 1'b0; inj_en = 1'b0; inj_copy = '0; inj_addr = '0; inj_mask = '0;
    #3;
    checkOutput("rst/rd_data", 32'(rd_data), 32'h0);
    checkOutput("rst/rd_mismatch", 32'(rd_mismatch), 32'h0);
    checkOutput("rst/busy", 32'(scrub_busy), 32'h0);
    checkOutput("rst/ptr", 32'(scrub_ptr), 32'h0);
    checkOutput("rst/count", 32'(fix_count), 32'h0);
    checkOutput("rst/pulse", 32'(fix_pulse), 32'h0);
    tick(); tick();
    rstn = 1'b1;

    // Write then read back; untouched addresses stay zero.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    readCheck("write3", 4'd3, 8'hA5, 1'b0);
    foreach (others[i]) readCheck("other", others[i], 8'h00, 1'b0);

    // Copy index 3 is ignored; a single-copy fault is masked by the vote.
    applyStimulus(2'd3, 4'd3, 8'hFF);
    readCheck("inj_ignored", 4'd3, 8'hA5, 1'b0);
    applyStimulus(2'd1, 4'd3, 8'h0F);
    readCheck("injB3", 4'd3, 8'hA5, 1'b1);

    // Scrubbing from ptr 0: check of ptr 3 commits on the 21st edge.
    scrub_en = 1'b1;
    waitFix(40, cyc);
    checkOutput("fix3/latency", 32'(cyc), 32'd21);
    checkOutput("fix3/count", 32'(fix_count), 32'd1);
    checkOutput("fix3/ptr", 32'(scrub_ptr), 32'd4);
    readCheck("fix3", 4'd3, 8'hA5, 1'b0);
    scrub_en = 1'b0;
    tick();
    checkOutput("fix3/pulse_end", 32'(fix_pulse), 32'h0);
    checkOutput("pause/busy", 32'(scrub_busy), 32'h0);
    checkOutput("pause/ptr", 32'(scrub_ptr), 32'd4);

    // Double fault in copies A and B is voted to the wrong value and then committed.
    applyStimulus(2'd0, 4'd5, 8'h01);
    applyStimulus(2'd1, 4'd5, 8'h01);
    readCheck("dbl5", 4'd5, 8'h01, 1'b1);
    scrub_en = 1'b1;
    waitFix(40, cyc);
    checkOutput("fix5/latency", 32'(cyc), 32'd11);
    checkOutput("fix5/count", 32'(fix_count), 32'd2);
    checkOutput("fix5/ptr", 32'(scrub_ptr), 32'd6);
    readCheck("fix5", 4'd5, 8'h01, 1'b0);
    scrub_en = 1'b0;
    tick();

    // Write lands during the CHECK of the same address: write wins, no correction.
    applyStimulus(2'd2, 4'd6, 8'hFF);
    readCheck("injC6", 4'd6, 8'h00, 1'b1);
    scrub_en = 1'b1;
    repeat (5) tick();
    checkOutput("coll/busy", 32'(scrub_busy), 32'h1);
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 8'h3C; scrub_en = 1'b0;
    tick();
    wr_en = 1'b0;
    checkOutput("coll/pulse", 32'(fix_pulse), 32'h0);
    checkOutput("coll/count", 32'(fix_count), 32'd2);
    checkOutput("coll/ptr", 32'(scrub_ptr), 32'd7);
    checkOutput("coll/busy_off", 32'(scrub_busy), 32'h0);
    readCheck("coll", 4'd6, 8'h3C, 1'b0);

    // Full-bank fault rounds of 16 corrections each drive the counter into saturation.
    for (int k = 1; k <= 17; k++) begin
      scrubRound(pulses);
      expCnt = (2 + 16 * k > 255) ? 255 : 2 + 16 * k;
      checkOutput($sformatf("round%0d/pulses", k), 32'(pulses), 32'd16);
      checkOutput($sformatf("round%0d/count", k), 32'(fix_count), 32'(expCnt));
    end
    checkOutput("rounds/ptr", 32'(scrub_ptr), 32'd7);

    // Clear coinciding with a correction leaves the counter at zero.
    applyStimulus(2'd0, 4'd7, 8'h01);
    scrub_en = 1'b1;
    repeat (5) tick();
    cnt_clr = 1'b1; scrub_en = 1'b0;
    tick();
    cnt_clr = 1'b0;
    checkOutput("clr/pulse", 32'(fix_pulse), 32'h1);
    checkOutput("clr/count", 32'(fix_count), 32'd0);
    checkOutput("clr/ptr", 32'(scrub_ptr), 32'd8);
    readCheck("clr", 4'd7, 8'h00, 1'b0);

    // Pause during GAP at the last address, then resume and wrap.
    scrub_en = 1'b1;
    repeat (36) tick();
    checkOutput("last/ptr", 32'(scrub_ptr), 32'd15);
    checkOutput("last/busy", 32'(scrub_busy), 32'h1);
    scrub_en = 1'b0;
    tick();
    checkOutput("last/idle", 32'(scrub_busy), 32'h0);
    repeat (3) tick();
    checkOutput("last/held", 32'(scrub_ptr), 32'd15);
    applyStimulus(2'd0, 4'd15, 8'h55);
    readCheck("injA15", 4'd15, 8'h00, 1'b1);
    scrub_en = 1'b1;
    repeat (6) tick();
    checkOutput("wrap/pulse", 32'(fix_pulse), 32'h1);
    checkOutput("wrap/ptr", 32'(scrub_ptr), 32'd0);
    checkOutput("wrap/count", 32'(fix_count), 32'd1);
    readCheck("wrap", 4'd15, 8'h00, 1'b0);
    repeat (5) tick();
    checkOutput("mid/ptr", 32'(scrub_ptr), 32'd1);
    checkOutput("mid/busy", 32'(scrub_busy), 32'h1);
    readCheck("mid", 4'd3, 8'hA5, 1'b0);

    // Asynchronous reset in the middle of a GAP clears everything at once.
    rstn = 1'b0;
    #1;
    checkOutput("arst/rd_data", 32'(rd_data), 32'h0);
    checkOutput("arst/rd_mismatch", 32'(rd_mismatch), 32'h0);
    checkOutput("arst/busy", 32'(scrub_busy), 32'h0);
    checkOutput("arst/ptr", 32'(scrub_ptr), 32'h0);
    checkOutput("arst/count", 32'(fix_count), 32'h0);
    checkOutput("arst/pulse", 32'(fix_pulse), 32'h0);
    scrub_en = 1'b0;
    tick();
    rstn = 1'b1;

    // After reset the scrubber restarts at address 0.
    applyStimulus(2'd1, 4'd0, 8'h22);
    scrub_en = 1'b1;
    waitFix(40, cyc);
    checkOutput("resume/latency", 32'(cyc), 32'd6);
    checkOutput("resume/ptr", 32'(scrub_ptr), 32'd1);
    checkOutput("resume/count", 32'(fix_count), 32'd1);
    scrub_en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
